game_state_controller: RTL and testbench
========================================

Name: game_state_controller

Overview:
Parametrised successor to the top-level IDLE/RUNNING game sequencer. It owns lives, level, frog facing direction and the game-phase state machine. It adds respawn grace, level-clear pause, timed game-over and edge-qualified collision and start events. It sits between the debounced switches, Collisions and Character_Control, and drives the life LEDs, the 7-segment level input and the game-active gating.

Parameters:
NUM_LIVES, 4, lives at start; width of the thermometer life vector (1..8)
GRACE_CYCLES, 25000000, cycles spent in RESPAWN (collisions ignored, frog frozen)
CLEAR_CYCLES, 12500000, cycles spent in LEVEL_CLEAR after a level-up
OVER_CYCLES, 50000000, cycles spent in GAME_OVER before returning to IDLE
MAX_LEVEL, 15, level saturation value (fits 4 bits)

Ports:
i_Clk  in  1  system clock
i_Rst_N  in  1  asynchronous active-low reset
i_Start  in  1  AND of the four debounced switches
i_Dir_Sw  in  4  debounced switches [0]=up [1]=left [2]=right [3]=down
i_Has_Collided  in  1  level-high collision flag from Collisions
i_Level_Up  in  1  one-cycle pulse from Character_Control when the frog reaches the top
o_State  out  3  encoded state for debug/display
o_Game_Active  out  1  high only in RUNNING
o_Lives  out  NUM_LIVES  thermometer life vector, LSB-aligned, drives LEDs
o_Level  out  4  current level, 0-based
o_Frog_Direction  out  2  0 up, 1 left, 2 right, 3 down
o_Respawn  out  1  one-cycle pulse on entering RESPAWN
o_Game_Over  out  1  high throughout GAME_OVER

Behaviour:
- Reset (async, i_Rst_N=0): state IDLE. o_Lives=0. o_Level=0. o_Frog_Direction=0. o_Respawn=0. o_Game_Over=0. Phase counter=0.
- Reset values of the edge-detect registers: start_q=1 and coll_q=1. A switch held through reset therefore does not start a game.
- Start event = i_Start & ~start_q. Collision event = i_Has_Collided & ~coll_q. Both registered every cycle in all states.
- Direction: updates every cycle. Priority is up > left > right > down. It holds its last value when no switch is pressed. It is independent of state.
- IDLE: on a start event -> RUNNING. Lives are set to all-ones, level to 0 and the counter is cleared.
- RUNNING:
  - Collision event with o_Lives==1 (single life left): lives -> 0, then -> GAME_OVER.
  - Collision event otherwise: lives shift right by 1, o_Respawn=1 for one cycle, then -> RESPAWN.
  - i_Level_Up with no collision event: level increments, saturating at MAX_LEVEL, then -> LEVEL_CLEAR.
  - Collision and level-up in the same cycle: the collision wins and the level is not incremented.
- RESPAWN: counts 0..GRACE_CYCLES-1, then -> RUNNING. All collisions are ignored. Level-up is ignored.
- LEVEL_CLEAR: counts CLEAR_CYCLES, then -> RUNNING. Collisions are ignored.
- GAME_OVER: o_Game_Over=1. Counts OVER_CYCLES, then -> IDLE. Lives stay 0 and level is held for display. Start events are ignored here.
- The counter clears on every state entry. Its width is $clog2 of the largest cycle parameter plus 1. It never wraps.
- Any state outside the legal set -> IDLE on the next cycle.
- Latency: every output is registered and changes one cycle after the qualifying input edge.
- Reset mid-game returns to IDLE immediately. No event is latched across reset.

Decomposition:
- Shared constants package (Constants.v): the state encodings IDLE=0, RUNNING=1, RESPAWN=2, LEVEL_CLEAR=3, GAME_OVER=4, plus the default cycle constants. Frogger_Game and Sprite_Display can then decode o_State.
- Sub-module phase_timer: a loadable down/up counter with a done pulse, instantiated once and reused across the three timed states.

Test Plan:
1. Start: hold i_Start=1 through reset release -> stays IDLE. Drop then raise i_Start -> RUNNING on the next cycle, o_Lives=4'b1111, o_Level=0, o_Game_Active=1.
2. Collision edge and grace (GRACE_CYCLES=8): i_Has_Collided held high for 20 cycles in RUNNING -> o_Lives=4'b0111, one o_Respawn pulse, RESPAWN for exactly 8 cycles. No further decrement, since the flag is still high with no new edge.
3. Level up (CLEAR_CYCLES=4, MAX_LEVEL=2): three i_Level_Up pulses, each after returning to RUNNING -> o_Level goes 1, 2, 2 (saturated). LEVEL_CLEAR lasts 4 cycles each time.
4. Simultaneous events: collision edge and i_Level_Up in the same cycle -> RESPAWN, o_Level unchanged, lives decremented.
5. Game over (OVER_CYCLES=6): four collision edges separated by grace periods -> o_Lives reaches 0, o_Game_Over high for 6 cycles, then IDLE. A start event during GAME_OVER is ignored.
6. Direction and reset: i_Dir_Sw=4'b0110 -> o_Frog_Direction=1. Then 4'b0000 -> holds 1. Assert i_Rst_N=0 mid-RESPAWN -> immediately IDLE, o_Lives=0, o_Frog_Direction=0.

Source files
------------

// File: rtl/game_state_controller_pkg.sv
// Shared constants for the game sequencer: state encodings decoded by the
// display blocks, default phase lengths, field widths and small helpers.
package game_state_controller_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned DIR_W   = 2;
  localparam int unsigned SW_W    = 4;

  // Game phase encodings (o_State)
  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUNNING     = 3'd1;
  localparam logic [STATE_W-1:0] ST_RESPAWN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_LEVEL_CLEAR = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAME_OVER   = 3'd4;

  // Frog facing encodings
  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd2;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd3;

  // Default phase lengths at a 50 MHz clock
  localparam int unsigned DEF_NUM_LIVES    = 4;
  localparam int unsigned DEF_GRACE_CYCLES = 25_000_000;
  localparam int unsigned DEF_CLEAR_CYCLES = 12_500_000;
  localparam int unsigned DEF_OVER_CYCLES  = 50_000_000;
  localparam int unsigned DEF_MAX_LEVEL    = 15;

  // Largest of three values, used to size the shared phase counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Switch-to-direction priority up > left > right > down; hold when idle
  function automatic logic [DIR_W-1:0] dir_decode(input logic [SW_W-1:0]  sw,
                                                  input logic [DIR_W-1:0] hold);
    logic [DIR_W-1:0] d;
    d = hold;
    if (sw[0])      d = DIR_UP;
    else if (sw[1]) d = DIR_LEFT;
    else if (sw[2]) d = DIR_RIGHT;
    else if (sw[3]) d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Switch/event inputs and status outputs of the game sequencer.
//   master : environment side (drives switches and events, reads status)
//   slave  : controller side
interface game_state_controller_if
  import game_state_controller_pkg::*;
#(
  parameter int unsigned NUM_LIVES = DEF_NUM_LIVES
);

  logic                 i_Start;
  logic [SW_W-1:0]      i_Dir_Sw;
  logic                 i_Has_Collided;
  logic                 i_Level_Up;
  logic [STATE_W-1:0]   o_State;
  logic                 o_Game_Active;
  logic [NUM_LIVES-1:0] o_Lives;
  logic [LEVEL_W-1:0]   o_Level;
  logic [DIR_W-1:0]     o_Frog_Direction;
  logic                 o_Respawn;
  logic                 o_Game_Over;

  modport master (
    output i_Start, i_Dir_Sw, i_Has_Collided, i_Level_Up,
    input  o_State, o_Game_Active, o_Lives, o_Level, o_Frog_Direction,
           o_Respawn, o_Game_Over
  );

  modport slave (
    input  i_Start, i_Dir_Sw, i_Has_Collided, i_Level_Up,
    output o_State, o_Game_Active, o_Lives, o_Level, o_Frog_Direction,
           o_Respawn, o_Game_Over
  );

endinterface

// File: rtl/game_state_controller_phase_timer.sv
// Shared phase counter: clears on request, counts up while enabled and flags
// the last cycle of the phase (count == limit-1). It stops there, never wraps.
// Ports: i_Clk, i_Rst_N, i_clear (restart at 0), i_enable (phase is timed),
//        i_limit (phase length in cycles), o_done_c (combinational last-cycle flag)
module game_state_controller_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_N,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done_c
);

  logic [CNT_W-1:0] count_q;

  assign o_done_c = i_enable && (count_q == (i_limit - CNT_W'(1)));

  // Counter register
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (i_enable && !o_done_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// Game phase sequencer: owns lives, level, frog facing and the
// IDLE/RUNNING/RESPAWN/LEVEL_CLEAR/GAME_OVER state machine.
// Ports: i_Clk, i_Rst_N (async active-low), bus (slave modport) carrying
//        start/direction switches, collision and level-up events in, and
//        state, active, lives, level, direction, respawn and game-over out.
module game_state_controller
  import game_state_controller_pkg::*;
#(
  parameter int unsigned NUM_LIVES    = DEF_NUM_LIVES,
  parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int unsigned OVER_CYCLES  = DEF_OVER_CYCLES,
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_N,
  game_state_controller_if.slave bus
);

  localparam int unsigned MAX_CYC = max3(GRACE_CYCLES, CLEAR_CYCLES, OVER_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [NUM_LIVES-1:0] LIVES_ONE = NUM_LIVES'(1);
  localparam logic [LEVEL_W-1:0]   LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  logic [STATE_W-1:0]   state_q,     state_nxt;
  logic [NUM_LIVES-1:0] lives_q,     lives_nxt;
  logic [LEVEL_W-1:0]   level_q,     level_nxt;
  logic [DIR_W-1:0]     dir_q,       dir_nxt;
  logic                 respawn_q,   respawn_nxt;
  logic                 game_over_q, game_over_nxt;
  logic                 active_q,    active_nxt;
  logic                 start_q;
  logic                 coll_q;

  logic                 start_ev_c;
  logic                 coll_ev_c;
  logic                 timer_clear_c;
  logic                 timer_en_c;
  logic [CNT_W-1:0]     timer_limit_c;
  logic                 timer_done_c;

  game_state_controller_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .i_Clk    (i_Clk),
    .i_Rst_N  (i_Rst_N),
    .i_clear  (timer_clear_c),
    .i_enable (timer_en_c),
    .i_limit  (timer_limit_c),
    .o_done_c (timer_done_c)
  );

  // Registers; edge detectors reset high so a switch held through reset is no event
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state_q     <= ST_IDLE;
      lives_q     <= '0;
      level_q     <= '0;
      dir_q       <= DIR_UP;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      active_q    <= 1'b0;
      start_q     <= 1'b1;
      coll_q      <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      lives_q     <= lives_nxt;
      level_q     <= level_nxt;
      dir_q       <= dir_nxt;
      respawn_q   <= respawn_nxt;
      game_over_q <= game_over_nxt;
      active_q    <= active_nxt;
      start_q     <= bus.i_Start;
      coll_q      <= bus.i_Has_Collided;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state_q;
    lives_nxt     = lives_q;
    level_nxt     = level_q;
    respawn_nxt   = 1'b0;
    timer_en_c    = 1'b0;
    timer_limit_c = '0;

    start_ev_c = bus.i_Start & ~start_q;
    coll_ev_c  = bus.i_Has_Collided & ~coll_q;
    dir_nxt    = dir_decode(bus.i_Dir_Sw, dir_q);

    case (state_q)
      ST_IDLE: begin
        if (start_ev_c) begin
          state_nxt = ST_RUNNING;
          lives_nxt = '1;
          level_nxt = '0;
        end
      end
      ST_RUNNING: begin
        // Collision takes priority over a same-cycle level-up
        if (coll_ev_c) begin
          if (lives_q == LIVES_ONE) begin
            lives_nxt = '0;
            state_nxt = ST_GAME_OVER;
          end else begin
            lives_nxt   = lives_q >> 1;
            respawn_nxt = 1'b1;
            state_nxt   = ST_RESPAWN;
          end
        end else if (bus.i_Level_Up) begin
          if (level_q < LEVEL_MAX) level_nxt = level_q + LEVEL_W'(1);
          state_nxt = ST_LEVEL_CLEAR;
        end
      end
      ST_RESPAWN: begin
        timer_en_c    = 1'b1;
        timer_limit_c = CNT_W'(GRACE_CYCLES);
        if (timer_done_c) state_nxt = ST_RUNNING;
      end
      ST_LEVEL_CLEAR: begin
        timer_en_c    = 1'b1;
        timer_limit_c = CNT_W'(CLEAR_CYCLES);
        if (timer_done_c) state_nxt = ST_RUNNING;
      end
      ST_GAME_OVER: begin
        timer_en_c    = 1'b1;
        timer_limit_c = CNT_W'(OVER_CYCLES);
        if (timer_done_c) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Restart the phase counter on every state change
    timer_clear_c = (state_nxt != state_q);
    active_nxt    = (state_nxt == ST_RUNNING);
    game_over_nxt = (state_nxt == ST_GAME_OVER);
  end

  assign bus.o_State          = state_q;
  assign bus.o_Game_Active    = active_q;
  assign bus.o_Lives          = lives_q;
  assign bus.o_Level          = level_q;
  assign bus.o_Frog_Direction = dir_q;
  assign bus.o_Respawn        = respawn_q;
  assign bus.o_Game_Over      = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with short phase lengths.
module tb_game_state_controller;
  import game_state_controller_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned GR = 8;
  localparam int unsigned CL = 4;
  localparam int unsigned OV = 6;
  localparam int unsigned ML = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  game_state_controller_if #(.NUM_LIVES(NL)) bus ();

  game_state_controller #(
    .NUM_LIVES    (NL),
    .GRACE_CYCLES (GR),
    .CLEAR_CYCLES (CL),
    .OVER_CYCLES  (OV),
    .MAX_LEVEL    (ML)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_N (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_Start = 1'b1;
    bus.i_Dir_Sw = 4'b0000;
    bus.i_Has_Collided = 1'b0;
    bus.i_Level_Up = 1'b0;
    tick(); tick();
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.o_State, ST_IDLE); end
    n_vec++; if (bus.o_Lives !== 4'b0000) begin n_err++; $display("FAIL reset_lives: got %b want 0000", bus.o_Lives); end
    n_vec++; if (bus.o_Level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.o_Level); end
    n_vec++; if (bus.o_Frog_Direction !== 2'd0) begin n_err++; $display("FAIL reset_dir: got %0d want 0", bus.o_Frog_Direction); end
    n_vec++; if (bus.o_Respawn !== 1'b0 || bus.o_Game_Over !== 1'b0 || bus.o_Game_Active !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got resp=%b over=%b act=%b want 0 0 0", bus.o_Respawn, bus.o_Game_Over, bus.o_Game_Active);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL held_start_no_game: got %0d want %0d", bus.o_State, ST_IDLE); end
  endtask

  task automatic test_start();
    bus.i_Start = 1'b0;
    tick();
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL idle_before_edge: got %0d want %0d", bus.o_State, ST_IDLE); end
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL start_state: got %0d want %0d", bus.o_State, ST_RUNNING); end
    n_vec++; if (bus.o_Lives !== 4'b1111) begin n_err++; $display("FAIL start_lives: got %b want 1111", bus.o_Lives); end
    n_vec++; if (bus.o_Level !== 4'd0) begin n_err++; $display("FAIL start_level: got %0d want 0", bus.o_Level); end
    n_vec++; if (bus.o_Game_Active !== 1'b1) begin n_err++; $display("FAIL start_active: got %b want 1", bus.o_Game_Active); end
  endtask

  task automatic test_collision_grace();
    int dur;
    int pulses;
    bus.i_Has_Collided = 1'b1;
    tick();
    n_vec++; if (bus.o_State !== ST_RESPAWN) begin n_err++; $display("FAIL coll_state: got %0d want %0d", bus.o_State, ST_RESPAWN); end
    n_vec++; if (bus.o_Lives !== 4'b0111) begin n_err++; $display("FAIL coll_lives: got %b want 0111", bus.o_Lives); end
    n_vec++; if (bus.o_Respawn !== 1'b1) begin n_err++; $display("FAIL coll_respawn_pulse: got %b want 1", bus.o_Respawn); end
    n_vec++; if (bus.o_Game_Active !== 1'b0) begin n_err++; $display("FAIL coll_inactive: got %b want 0", bus.o_Game_Active); end
    dur = 1;
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (bus.o_State === ST_RESPAWN) dur++;
      if (bus.o_Respawn === 1'b1) pulses++;
    end
    n_vec++; if (dur != int'(GR)) begin n_err++; $display("FAIL grace_len: got %0d want %0d", dur, GR); end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL extra_respawn_pulses: got %0d want 0", pulses); end
    n_vec++; if (bus.o_Lives !== 4'b0111) begin n_err++; $display("FAIL held_flag_lives: got %b want 0111", bus.o_Lives); end
    n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL grace_return: got %0d want %0d", bus.o_State, ST_RUNNING); end
    bus.i_Has_Collided = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    bus.i_Has_Collided = 1'b1;
    bus.i_Level_Up = 1'b1;
    tick();
    bus.i_Has_Collided = 1'b0;
    bus.i_Level_Up = 1'b0;
    n_vec++; if (bus.o_State !== ST_RESPAWN) begin n_err++; $display("FAIL simul_state: got %0d want %0d", bus.o_State, ST_RESPAWN); end
    n_vec++; if (bus.o_Level !== 4'd0) begin n_err++; $display("FAIL simul_level: got %0d want 0", bus.o_Level); end
    n_vec++; if (bus.o_Lives !== 4'b0011) begin n_err++; $display("FAIL simul_lives: got %b want 0011", bus.o_Lives); end
    for (int i = 0; i < int'(GR) + 4; i++) begin
      tick();
      if (bus.o_State !== ST_RESPAWN) break;
    end
    n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL simul_return: got %0d want %0d", bus.o_State, ST_RUNNING); end
  endtask

  task automatic test_level_up();
    logic [3:0] exp_lvl [3];
    int dur;
    exp_lvl[0] = 4'd1;
    exp_lvl[1] = 4'd2;
    exp_lvl[2] = 4'd2;
    for (int k = 0; k < 3; k++) begin
      bus.i_Level_Up = 1'b1;
      tick();
      bus.i_Level_Up = 1'b0;
      n_vec++; if (bus.o_State !== ST_LEVEL_CLEAR) begin n_err++; $display("FAIL lvl%0d_state: got %0d want %0d", k, bus.o_State, ST_LEVEL_CLEAR); end
      n_vec++; if (bus.o_Level !== exp_lvl[k]) begin n_err++; $display("FAIL lvl%0d_level: got %0d want %0d", k, bus.o_Level, exp_lvl[k]); end
      dur = 1;
      for (int i = 0; i < int'(CL) + 4; i++) begin
        tick();
        if (bus.o_State === ST_LEVEL_CLEAR) dur++;
        else break;
      end
      n_vec++; if (dur != int'(CL)) begin n_err++; $display("FAIL lvl%0d_clear_len: got %0d want %0d", k, dur, CL); end
      n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL lvl%0d_return: got %0d want %0d", k, bus.o_State, ST_RUNNING); end
    end
  endtask

  task automatic test_game_over();
    int dur;
    bus.i_Has_Collided = 1'b1;
    tick();
    bus.i_Has_Collided = 1'b0;
    n_vec++; if (bus.o_Lives !== 4'b0001) begin n_err++; $display("FAIL go_pre_lives: got %b want 0001", bus.o_Lives); end
    for (int i = 0; i < int'(GR) + 4; i++) begin
      tick();
      if (bus.o_State !== ST_RESPAWN) break;
    end
    n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL go_pre_return: got %0d want %0d", bus.o_State, ST_RUNNING); end
    bus.i_Has_Collided = 1'b1;
    tick();
    bus.i_Has_Collided = 1'b0;
    n_vec++; if (bus.o_State !== ST_GAME_OVER) begin n_err++; $display("FAIL go_state: got %0d want %0d", bus.o_State, ST_GAME_OVER); end
    n_vec++; if (bus.o_Lives !== 4'b0000) begin n_err++; $display("FAIL go_lives: got %b want 0000", bus.o_Lives); end
    n_vec++; if (bus.o_Game_Over !== 1'b1) begin n_err++; $display("FAIL go_flag: got %b want 1", bus.o_Game_Over); end
    n_vec++; if (bus.o_Respawn !== 1'b0) begin n_err++; $display("FAIL go_no_respawn: got %b want 0", bus.o_Respawn); end
    n_vec++; if (bus.o_Level !== 4'd2) begin n_err++; $display("FAIL go_level_held: got %0d want 2", bus.o_Level); end
    dur = 1;
    for (int i = 0; i < int'(OV) + 4; i++) begin
      if (i == 1) bus.i_Start = 1'b1;
      if (i == 2) bus.i_Start = 1'b0;
      tick();
      if (bus.o_State === ST_GAME_OVER) dur++;
      else break;
    end
    n_vec++; if (dur != int'(OV)) begin n_err++; $display("FAIL go_len: got %0d want %0d", dur, OV); end
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL go_to_idle: got %0d want %0d", bus.o_State, ST_IDLE); end
    n_vec++; if (bus.o_Game_Over !== 1'b0) begin n_err++; $display("FAIL go_flag_clear: got %b want 0", bus.o_Game_Over); end
    tick(); tick();
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL go_start_ignored: got %0d want %0d", bus.o_State, ST_IDLE); end
  endtask

  task automatic test_direction_reset();
    logic [3:0] sw_v  [6];
    logic [1:0] dir_v [6];
    sw_v[0] = 4'b0110; dir_v[0] = 2'd1;
    sw_v[1] = 4'b0000; dir_v[1] = 2'd1;
    sw_v[2] = 4'b1000; dir_v[2] = 2'd3;
    sw_v[3] = 4'b1100; dir_v[3] = 2'd2;
    sw_v[4] = 4'b1111; dir_v[4] = 2'd0;
    sw_v[5] = 4'b0000; dir_v[5] = 2'd0;
    for (int k = 0; k < 6; k++) begin
      bus.i_Dir_Sw = sw_v[k];
      tick();
      n_vec++; if (bus.o_Frog_Direction !== dir_v[k]) begin n_err++; $display("FAIL dir_%b: got %0d want %0d", sw_v[k], bus.o_Frog_Direction, dir_v[k]); end
    end
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    n_vec++; if (bus.o_State !== ST_RUNNING) begin n_err++; $display("FAIL restart_state: got %0d want %0d", bus.o_State, ST_RUNNING); end
    bus.i_Dir_Sw = 4'b0110;
    tick();
    bus.i_Has_Collided = 1'b1;
    tick();
    n_vec++; if (bus.o_State !== ST_RESPAWN || bus.o_Frog_Direction !== 2'd1) begin
      n_err++; $display("FAIL pre_reset: got state=%0d dir=%0d want %0d 1", bus.o_State, bus.o_Frog_Direction, ST_RESPAWN);
    end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL midgame_reset_state: got %0d want %0d", bus.o_State, ST_IDLE); end
    n_vec++; if (bus.o_Lives !== 4'b0000) begin n_err++; $display("FAIL midgame_reset_lives: got %b want 0000", bus.o_Lives); end
    n_vec++; if (bus.o_Frog_Direction !== 2'd0) begin n_err++; $display("FAIL midgame_reset_dir: got %0d want 0", bus.o_Frog_Direction); end
    n_vec++; if (bus.o_Game_Active !== 1'b0 || bus.o_Respawn !== 1'b0) begin
      n_err++; $display("FAIL midgame_reset_flags: got act=%b resp=%b want 0 0", bus.o_Game_Active, bus.o_Respawn);
    end
    tick();
    rst_n = 1'b1;
    bus.i_Dir_Sw = 4'b0000;
    bus.i_Has_Collided = 1'b0;
    tick(); tick();
    n_vec++; if (bus.o_State !== ST_IDLE) begin n_err++; $display("FAIL post_reset_idle: got %0d want %0d", bus.o_State, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_collision_grace();
    test_simultaneous();
    test_level_up();
    test_game_over();
    test_direction_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
